mem_wb_stage: RTL and testbench

- Writeback-side stage directly downstream of the memory stage.
- Selects the register-file write data from the memory-stage results and holds it in the MEM/WB pipeline register (valid, stall, flush).
- Drives the register-file write port and a forwarding tap.
- Tracks halt retirement, sticky write-source errors and a retired-instruction count.

---
 rtl/mem_wb_stage_pkg.sv | 19 +
 rtl/mem_wb_if.sv | 48 ++++
 rtl/mem_wb_stage_mux.sv | 37 +++
 rtl/mem_wb_stage.sv | 84 ++++++++
 tb/tb_mem_wb_stage.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM/WB writeback stage: write-source encodings
// and default datapath widths.
package mem_wb_stage_pkg;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_REG_AW = 3;
   localparam int DEF_CNT_W  = 16;

   typedef enum logic [2:0] {
      WB_SRC_MEM   = 3'd0,
      WB_SRC_ALU   = 3'd1,
      WB_SRC_PC    = 3'd2,
      WB_SRC_SET   = 3'd3,
      WB_SRC_SEXT8 = 3'd4,
      WB_SRC_LBI   = 3'd5,
      WB_SRC_BREV  = 3'd6
   } wb_src_e;

endpackage

// File: rtl/mem_wb_if.sv
// Bundle between the memory stage, the MEM/WB register and its consumers
// (register-file write port, forwarding tap, status).
interface mem_wb_if
   import mem_wb_stage_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int REG_AW = DEF_REG_AW,
   parameter int CNT_W  = DEF_CNT_W
);
   logic              validIn;
   logic              stall;
   logic              flush;
   logic [DATA_W-1:0] memOut;
   logic [DATA_W-1:0] aluOut;
   logic [DATA_W-1:0] nextPc;
   logic [DATA_W-1:0] setVal;
   logic [DATA_W-1:0] instr;
   logic [DATA_W-1:0] reg1Data;
   logic              regWrtIn;
   logic [2:0]        regWrtSrcIn;
   logic [REG_AW-1:0] writeRegIn;
   logic              haltIn;

   logic              wbEn;
   logic [REG_AW-1:0] wbReg;
   logic [DATA_W-1:0] wbData;
   logic              fwdValid;
   logic [REG_AW-1:0] fwdReg;
   logic [DATA_W-1:0] fwdData;
   logic              halted;
   logic              err;
   logic [CNT_W-1:0]  retireCount;

   modport master (
      output validIn, stall, flush, memOut, aluOut, nextPc, setVal, instr,
             reg1Data, regWrtIn, regWrtSrcIn, writeRegIn, haltIn,
      input  wbEn, wbReg, wbData, fwdValid, fwdReg, fwdData, halted, err,
             retireCount
   );

   modport slave (
      input  validIn, stall, flush, memOut, aluOut, nextPc, setVal, instr,
             reg1Data, regWrtIn, regWrtSrcIn, writeRegIn, haltIn,
      output wbEn, wbReg, wbData, fwdValid, fwdReg, fwdData, halted, err,
             retireCount
   );

endinterface

// File: rtl/mem_wb_stage_mux.sv
// Register-file write-data selection; purely combinational. Source 7 has no
// meaning and yields zero data with the illegal flag raised.
module wb_data_mux
   import mem_wb_stage_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic [2:0]        src,
   input  logic [DATA_W-1:0] mem_data,
   input  logic [DATA_W-1:0] alu_data,
   input  logic [DATA_W-1:0] pc_data,
   input  logic [DATA_W-1:0] set_data,
   input  logic [7:0]        imm8,
   input  logic [DATA_W-1:0] reg1_data,
   output logic [DATA_W-1:0] sel_data,
   output logic              illegal
);

   always_comb begin
      sel_data = '0;
      illegal  = 1'b0;
      case (src)
         WB_SRC_MEM:   sel_data = mem_data;
         WB_SRC_ALU:   sel_data = alu_data;
         WB_SRC_PC:    sel_data = pc_data;
         WB_SRC_SET:   sel_data = set_data;
         WB_SRC_SEXT8: sel_data = {{(DATA_W-8){imm8[7]}}, imm8};
         WB_SRC_LBI:   sel_data = DATA_W'({reg1_data[7:0], imm8});
         WB_SRC_BREV: begin
            for (int i = 0; i < DATA_W; i++)
               sel_data[i] = reg1_data[DATA_W-1-i];
         end
         default:      illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with writeback/forwarding outputs, halt retirement,
// sticky illegal-source error and a saturating retired-instruction counter.
module mem_wb_stage
   import mem_wb_stage_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int REG_AW = DEF_REG_AW,
   parameter int CNT_W  = DEF_CNT_W
) (
   input logic   clk,
   input logic   rst,
   mem_wb_if.slave bus
);

   logic              valid;
   logic              wrt;
   logic              hlt;
   logic              halted_q;
   logic              err_q;
   logic [REG_AW-1:0] wb_reg_q;
   logic [DATA_W-1:0] wb_data_q;
   logic [CNT_W-1:0]  cnt_q;

   logic [DATA_W-1:0] sel_data;
   logic              illegal;
   logic              cap;
   logic              halt_retire;

   wb_data_mux #(.DATA_W(DATA_W)) u_mux (
      .src       (bus.regWrtSrcIn),
      .mem_data  (bus.memOut),
      .alu_data  (bus.aluOut),
      .pc_data   (bus.nextPc),
      .set_data  (bus.setVal),
      .imm8      (bus.instr[7:0]),
      .reg1_data (bus.reg1Data),
      .sel_data  (sel_data),
      .illegal   (illegal)
   );

   assign cap         = !bus.stall && !halted_q;
   assign halt_retire = valid && hlt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid     <= 1'b0;
         wrt       <= 1'b0;
         hlt       <= 1'b0;
         halted_q  <= 1'b0;
         err_q     <= 1'b0;
         wb_reg_q  <= '0;
         wb_data_q <= '0;
         cnt_q     <= '0;
      end else begin
         // A retiring HALT kills whatever would be captured alongside it.
         if (bus.flush || halt_retire) begin
            valid <= 1'b0;
         end else if (cap) begin
            valid     <= bus.validIn;
            wrt       <= bus.regWrtIn;
            hlt       <= bus.haltIn;
            wb_reg_q  <= bus.writeRegIn;
            wb_data_q <= sel_data;
         end
         if (halt_retire)
            halted_q <= 1'b1;
         if (cap && !bus.flush && bus.validIn && bus.regWrtIn && illegal)
            err_q <= 1'b1;
         if (valid && (cap || hlt) && (cnt_q != '1))
            cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign bus.wbEn        = valid && wrt && !hlt;
   assign bus.wbReg       = wb_reg_q;
   assign bus.wbData      = wb_data_q;
   assign bus.fwdValid    = bus.wbEn;
   assign bus.fwdReg      = wb_reg_q;
   assign bus.fwdData     = wb_data_q;
   assign bus.halted      = halted_q;
   assign bus.err         = err_q;
   assign bus.retireCount = cnt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized and directed bench for mem_wb_stage against a behavioural model
// of the writeback entry, halt, error and retire-count rules.
module tb_mem_wb_stage;
   import mem_wb_stage_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   mem_wb_if bus ();

   mem_wb_stage dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      bit        v;
      bit [2:0]  r;
      bit [15:0] d;
      bit        w;
      bit        h;
   } ent_t;

   ent_t        m_ent;
   bit          m_halted;
   bit          m_err;
   int unsigned m_cnt;
   int          n_chk = 0;
   int          n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [15:0] ref_data(input logic [2:0] src);
      int r;
      r = 0;
      case (src)
         3'd0: r = int'(bus.memOut);
         3'd1: r = int'(bus.aluOut);
         3'd2: r = int'(bus.nextPc);
         3'd3: r = int'(bus.setVal);
         3'd4: r = (int'(bus.instr[7:0]) >= 128) ? int'(bus.instr[7:0]) + 'hFF00
                                                  : int'(bus.instr[7:0]);
         3'd5: r = int'(bus.reg1Data[7:0]) * 256 + int'(bus.instr[7:0]);
         3'd6: for (int i = 0; i < 16; i++)
                  if (bus.reg1Data[i]) r += (1 << (15 - i));
         default: r = 0;
      endcase
      return r[15:0];
   endfunction

   task automatic model_reset();
      m_ent    = '{v: 0, r: 0, d: 0, w: 0, h: 0};
      m_halted = 0;
      m_err    = 0;
      m_cnt    = 0;
   endtask

   // Advance the model by one clock edge using the inputs currently applied.
   task automatic model_edge();
      bit   can_take;
      bit   retiring_halt;
      ent_t nxt;
      can_take      = !bus.stall && !m_halted;
      retiring_halt = m_ent.v && m_ent.h;
      nxt           = m_ent;
      if (m_ent.v && (can_take || m_ent.h) && m_cnt < 65535) m_cnt++;
      if (can_take && !bus.flush && bus.validIn && bus.regWrtIn && bus.regWrtSrcIn == 3'd7)
         m_err = 1;
      if (retiring_halt) m_halted = 1;
      if (bus.flush || retiring_halt) nxt.v = 0;
      else if (can_take)
         nxt = '{v: bus.validIn, r: bus.writeRegIn, d: ref_data(bus.regWrtSrcIn),
                 w: bus.regWrtIn, h: bus.haltIn};
      m_ent = nxt;
   endtask

   task automatic check_outs();
      bit en;
      en = m_ent.v && m_ent.w && !m_ent.h;
      chk("wbEn", bus.wbEn, en);
      chk("fwdValid", bus.fwdValid, en);
      chk("halted", bus.halted, m_halted);
      chk("err", bus.err, m_err);
      chk("retireCount", bus.retireCount, m_cnt[15:0]);
      if (m_ent.v) begin
         chk("wbReg", bus.wbReg, m_ent.r);
         chk("wbData", bus.wbData, m_ent.d);
         chk("fwdReg", bus.fwdReg, m_ent.r);
         chk("fwdData", bus.fwdData, m_ent.d);
      end
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      check_outs();
   endtask

   task automatic do_reset(input int n);
      rst = 1'b0;
      model_reset();
      #1;
      chk("rst_wbEn", bus.wbEn, 0);
      chk("rst_wbReg", bus.wbReg, 0);
      chk("rst_wbData", bus.wbData, 0);
      chk("rst_fwdValid", bus.fwdValid, 0);
      chk("rst_halted", bus.halted, 0);
      chk("rst_err", bus.err, 0);
      chk("rst_retireCount", bus.retireCount, 0);
      repeat (n) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   task automatic drive(input bit v, input bit w, input logic [2:0] src,
                        input logic [2:0] wreg, input bit h);
      bus.validIn     = v;
      bus.regWrtIn    = w;
      bus.regWrtSrcIn = src;
      bus.writeRegIn  = wreg;
      bus.haltIn      = h;
      bus.stall       = 1'b0;
      bus.flush       = 1'b0;
   endtask

   task automatic rand_data();
      bus.memOut   = 16'($urandom);
      bus.aluOut   = 16'($urandom);
      bus.nextPc   = 16'($urandom);
      bus.setVal   = 16'($urandom);
      bus.instr    = 16'($urandom);
      bus.reg1Data = 16'($urandom);
   endtask

   logic [15:0] c0;

   initial begin
      drive(0, 0, 3'd0, 3'd0, 0);
      rand_data();

      do_reset(3);
      #1;
      chk("post_rst_wbEn", bus.wbEn, 0);
      chk("post_rst_retireCount", bus.retireCount, 0);

      // first transaction
      drive(1, 1, 3'd1, 3'd3, 0);
      bus.aluOut = 16'h1234;
      step();
      chk("first_wbEn", bus.wbEn, 1);
      chk("first_wbReg", bus.wbReg, 3);
      chk("first_wbData", bus.wbData, 16'h1234);
      drive(0, 0, 3'd0, 3'd0, 0);
      step();
      chk("first_count", bus.retireCount, 1);

      // computed sources
      drive(1, 1, 3'd4, 3'd1, 0);
      bus.instr = 16'h1280;
      step();
      chk("sext8", bus.wbData, 16'hFF80);
      drive(1, 1, 3'd5, 3'd2, 0);
      bus.reg1Data = 16'h00AB;
      bus.instr    = 16'h77CD;
      step();
      chk("lbi", bus.wbData, 16'hABCD);
      drive(1, 1, 3'd6, 3'd4, 0);
      bus.reg1Data = 16'h0001;
      step();
      chk("brev", bus.wbData, 16'h8000);

      // stall holds the entry and it retires only once
      drive(1, 1, 3'd1, 3'd5, 0);
      bus.aluOut = 16'h5555;
      step();
      c0 = bus.retireCount;
      for (int i = 0; i < 3; i++) begin
         bus.stall  = 1'b1;
         bus.aluOut = 16'($urandom);
         step();
         chk("stall_hold", bus.wbData, 16'h5555);
      end
      drive(0, 0, 3'd1, 3'd0, 0);
      step();
      chk("stall_once", bus.retireCount, c0 + 16'd1);
      drive(1, 1, 3'd1, 3'd6, 0);
      step();
      bus.stall = 1'b1;
      bus.flush = 1'b1;
      step();
      chk("stall_flush", bus.wbEn, 0);

      // illegal source
      drive(1, 1, 3'd7, 3'd2, 0);
      step();
      chk("ill_err", bus.err, 1);
      chk("ill_wbEn", bus.wbEn, 1);
      chk("ill_data", bus.wbData, 0);
      drive(0, 0, 3'd1, 3'd0, 0);
      repeat (3) step();
      chk("ill_sticky", bus.err, 1);
      do_reset(1);
      drive(0, 1, 3'd7, 3'd2, 0);
      step();
      step();
      chk("ill_bubble", bus.err, 0);

      // halt
      do_reset(1);
      drive(1, 1, 3'd1, 3'd1, 1);
      step();
      chk("halt_wbEn", bus.wbEn, 0);
      drive(1, 1, 3'd1, 3'd1, 0);
      step();
      chk("halt_set", bus.halted, 1);
      c0 = bus.retireCount;
      for (int i = 0; i < 4; i++) begin
         rand_data();
         step();
         chk("halt_noen", bus.wbEn, 0);
         chk("halt_nocount", bus.retireCount, c0);
      end
      @(posedge clk);
      #3;
      do_reset(1);
      chk("halt_cleared", bus.halted, 0);

      // random traffic
      for (int n = 0; n < 3000; n++) begin
         bus.validIn     = ($urandom_range(0, 3) != 0);
         bus.regWrtIn    = ($urandom_range(0, 3) != 0);
         bus.regWrtSrcIn = 3'($urandom_range(0, 7));
         bus.writeRegIn  = 3'($urandom);
         bus.haltIn      = ($urandom_range(0, 60) == 0);
         bus.stall       = ($urandom_range(0, 4) == 0);
         bus.flush       = ($urandom_range(0, 9) == 0);
         rand_data();
         step();
         if ((m_halted || m_err) && $urandom_range(0, 15) == 0) do_reset(1);
      end

      // saturation
      do_reset(1);
      drive(1, 1, 3'd1, 3'd3, 0);
      while (m_cnt < 32'd65534) begin
         model_edge();
         @(posedge clk);
      end
      #1;
      chk("sat_preload", bus.retireCount, 16'hFFFE);
      for (int i = 0; i < 3; i++) step();
      chk("sat_max", bus.retireCount, 16'hFFFF);
      repeat (3) step();
      chk("sat_hold", bus.retireCount, 16'hFFFF);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
